image_rotate_stream: RTL and testbench
======================================

# image_rotate_stream

Streaming, synthesizable image rotator with parametrised frame size and fixed-point angle. A frame is written into an internal frame buffer over a valid/ready input stream. The block then emits an OUT_ROWS×OUT_COLS canvas in raster order over a valid/ready output stream. It uses inverse mapping with nearest-neighbour sampling, runs at one pixel per cycle, and takes its angle from run-time sin/cos inputs. It sits in the image pipeline between the pixel source (file/BRAM loader) and downstream filters or the file writer.

## Interface
- DATA_W, 8, pixel width
- ROWS, 242, input rows
- COLS, 247, input columns
- OUT_ROWS, 346, output rows (346 = ceil of the 242×247 diagonal)
- OUT_COLS, 346, output columns
- FRAC, 14, fractional bits of sin/cos and coordinate accumulators
- FILL, 0, value emitted for out-of-image samples
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  start-of-frame pulse; sampled only in IDLE
- cos_q  in  FRAC+2  signed cos θ (Q2.FRAC); latched on accepted start
- sin_q  in  FRAC+2  signed sin θ; latched on accepted start
- s_valid  in  1  input pixel valid
- s_ready  out  1  input ready; high only in LOAD
- s_data  in  DATA_W  input pixel, raster order
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream ready
- m_data  out  DATA_W  output pixel
- m_eol  out  1  qualifies the last pixel of an output row
- m_last  out  1  qualifies the last pixel of the frame
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the m_last handshake

## Operation
- States and transitions:
  - IDLE → LOAD on start.
  - LOAD → PREP after ROWS·COLS input beats (s_valid & s_ready).
  - PREP (1 cycle) → EMIT.
  - EMIT → IDLE after the m_last handshake; done pulses in the following cycle.
- Mapping for output pixel (u=col, v=row):
  - Centres: cx=(COLS-1)/2, cy=(ROWS-1)/2, ox=(OUT_COLS-1)/2, oy=(OUT_ROWS-1)/2, all exact in Q.FRAC.
  - x = cx + (u-ox)·cos + (v-oy)·sin
  - y = cy − (u-ox)·sin + (v-oy)·cos
- PREP computes the row-start (x0,y0) for (u=0,v=0) with the only multipliers in the block.
- In EMIT, coordinates are updated incrementally:
  - Per column: x+=cos, y−=sin.
  - Per new row: row-start x+=sin, y+=cos; then x,y reload from the row start.
- Accumulator width is FRAC+$clog2(max dim)+3 bits, signed. No overflow for |sin|,|cos|≤1.
- Sample index is floor(q + 2^(FRAC-1)) >>> FRAC (round half up, arithmetic shift).
- In-bounds requires 0≤xi<COLS and 0≤yi<ROWS; otherwise the sample is FILL (see Configuration).
- Frame buffer: ROWS·COLS×DATA_W with synchronous read. Address = yi·COLS+xi.
- start outside IDLE is ignored. s_valid outside LOAD is ignored.

## Timing
- Reset values: s_ready=0, m_valid=0, m_data=0, m_eol=0, m_last=0, busy=0, done=0, state=IDLE. Frame buffer contents are not reset.
- Reset mid-frame aborts immediately. No done pulse is produced, and the next frame must restart with start.
- start accepted at cycle t: s_ready=1 from t+1.
- EMIT pipeline has 3 stages: coordinate/bounds → RAM read → output register.
  - First m_valid no later than 4 cycles after the final input beat.
  - Sustained rate is 1 pixel/cycle while m_ready=1.
- Backpressure: when m_valid & !m_ready, the whole pipeline stalls.
  - m_data, m_eol and m_last hold stable; no pixel is dropped or duplicated.
  - m_valid is never deasserted without a handshake.
- m_eol is set when u=OUT_COLS-1. m_last is set when u=OUT_COLS-1 and v=OUT_ROWS-1. Both are asserted together with m_valid.

## Configuration
- ROTATE_EDGE_CLAMP_EN:
  - Defined: out-of-bounds xi/yi are clamped to [0,COLS-1]/[0,ROWS-1], so the nearest edge pixel is emitted and FILL is unused.
  - Undefined: out-of-bounds samples emit FILL.

## Structure
- Package image_pkg holds:
  - the state enum (IDLE, LOAD, PREP, EMIT)
  - an accumulator-width function
  - a fixed-point rounding function
  - Q-format constants (ONE_Q = 1<<FRAC)
- Sub-module frame_ram (single-port write, synchronous-read dual-port RAM, parametrised depth/width) is instantiated once.

## Test plan
- ROWS=COLS=OUT_ROWS=OUT_COLS=4, input 0..15, cos_q=16384, sin_q=0 → output 0..15; m_eol on 3,7,11,15; m_last on 15; done one cycle later.
- Same sizes, cos_q=−16384, sin_q=0 (180°) → output 15,14,…,0.
- Same sizes, cos_q=0, sin_q=16384 (90°) → output row 0 = 12,8,4,0; row 3 = 15,11,7,3.
- 4×4 input into 6×6 canvas at 0°, ROTATE_EDGE_CLAMP_EN undefined → row 0 all FILL; row 1 = FILL,0,1,2,3,FILL. With the macro defined → row 0 = 0,0,1,2,3,3.
- Random m_ready (≈50%) and random s_valid gaps on a 30° frame (cos_q=14189, sin_q=8192) → output stream identical to the m_ready=1 run; held data stable under stall.
- rst_n asserted mid-EMIT → all outputs at reset values asynchronously; start then rerun at 0° → correct frame with exactly one done.

Source files
------------

// File: rtl/image_pkg.sv
// Shared state encoding, pipeline metadata and fixed-point helpers for the image rotator.
package image_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, PREP, EMIT} state_t;

   // Flags travelling alongside a pixel through the emit pipeline.
   typedef struct packed {
      logic eol;
      logic last;
      logic inb;
   } pix_meta_t;

   localparam int DEF_FRAC = 14;
   localparam int ONE_Q    = 1 << DEF_FRAC;

   function automatic int max_dim(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   function automatic int acc_width(input int frac, input int dim);
      return frac + $clog2(dim) + 3;
   endfunction

   // Round half up to an integer index; the arithmetic shift floors negative values.
   function automatic logic signed [63:0] round_q(input logic signed [63:0] q, input int frac);
      return (q + (64'sd1 <<< (frac - 1))) >>> frac;
   endfunction

endpackage

// File: rtl/frame_ram.sv
// Frame buffer: one write port, one registered read port; latency 1 cycle.
// Read data holds while rd_en is low so the emit pipeline can stall on it.
module frame_ram #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 8,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_dat,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_dat
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_dat;
      if (rd_en) rd_dat <= mem[rd_addr];
   end

endmodule

// File: rtl/image_rotate_stream.sv
// Buffers a ROWS x COLS frame, then streams an OUT_ROWS x OUT_COLS canvas by inverse nearest-neighbour rotation.
// First m_valid 3 cycles after the final input beat; the emit pipe stalls whole on m_valid & !m_ready. ROTATE_EDGE_CLAMP_EN clamps edges instead of FILL.
module image_rotate_stream
   import image_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int ROWS     = 242,
   parameter int COLS     = 247,
   parameter int OUT_ROWS = 346,
   parameter int OUT_COLS = 346,
   parameter int FRAC     = DEF_FRAC,
   parameter logic [DATA_W-1:0] FILL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [FRAC+1:0]   cos_q,
   input  logic [FRAC+1:0]   sin_q,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_eol,
   output logic              m_last,
   output logic              busy,
   output logic              done
);

   localparam int MAXD  = max_dim(ROWS, COLS, OUT_ROWS, OUT_COLS);
   localparam int ACC_W = acc_width(FRAC, MAXD);
   localparam int IW    = ACC_W - FRAC;
   localparam int W2    = ACC_W + 2;
   localparam int DEPTH = ROWS * COLS;
   localparam int AW    = $clog2(DEPTH);
   localparam int UW    = $clog2(OUT_COLS + 1);
   localparam int VW    = $clog2(OUT_ROWS + 1);

   localparam logic signed [ACC_W-1:0] CX_Q = ACC_W'((COLS - 1) * (2 ** (FRAC - 1)));
   localparam logic signed [ACC_W-1:0] CY_Q = ACC_W'((ROWS - 1) * (2 ** (FRAC - 1)));
   localparam logic signed [W2-1:0]    OCM1 = W2'(OUT_COLS - 1);
   localparam logic signed [W2-1:0]    ORM1 = W2'(OUT_ROWS - 1);
   localparam logic signed [IW-1:0]    COLS_S = IW'(COLS);
   localparam logic signed [IW-1:0]    ROWS_S = IW'(ROWS);
   localparam logic [UW-1:0] U_LAST = UW'(OUT_COLS - 1);
   localparam logic [VW-1:0] V_LAST = VW'(OUT_ROWS - 1);
   localparam logic [AW-1:0] A_LAST = AW'(DEPTH - 1);

   state_t state, state_nxt;

   logic signed [FRAC+1:0]  cos_r, sin_r;
   logic signed [ACC_W-1:0] cos_e, sin_e;
   logic signed [W2-1:0]    cos_w, sin_w, px, py;
   logic signed [ACC_W-1:0] x0, y0;
   logic signed [ACC_W-1:0] x_acc, y_acc, xr_acc, yr_acc;
   logic [UW-1:0]           u_cnt;
   logic [VW-1:0]           v_cnt;
   logic                    gen_vld;

   logic signed [IW-1:0]    xi, yi, xs, ys;
   logic                    x_in, y_in, inb;
   logic [AW-1:0]           wr_addr, rd_addr;
   logic [DATA_W-1:0]       ram_q;

   logic                    in_beat, last_beat, out_hs, adv;
   logic                    vld2;
   pix_meta_t               meta2;

   assign s_ready   = (state == LOAD);
   assign busy      = (state != IDLE);
   assign in_beat   = s_ready & s_valid;
   assign last_beat = in_beat && (wr_addr == A_LAST);
   assign out_hs    = m_valid & m_ready;
   assign adv       = !m_valid || m_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = LOAD;
         LOAD:    if (last_beat) state_nxt = PREP;
         PREP:    state_nxt = EMIT;
         EMIT:    if (out_hs && m_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cos_r   <= '0;
         sin_r   <= '0;
         wr_addr <= '0;
      end else if (state == IDLE && start) begin
         cos_r   <= $signed(cos_q);
         sin_r   <= $signed(sin_q);
         wr_addr <= '0;
      end else if (in_beat) begin
         wr_addr <= wr_addr + AW'(1);
      end
   end

   // Canvas origin: centres are half-integers, so sum both products before halving.
   assign cos_w = W2'(cos_r);
   assign sin_w = W2'(sin_r);
   assign px    = -(OCM1 * cos_w) - (ORM1 * sin_w);
   assign py    = (OCM1 * sin_w) - (ORM1 * cos_w);
   assign x0    = CX_Q + ACC_W'(px >>> 1);
   assign y0    = CY_Q + ACC_W'(py >>> 1);
   assign cos_e = ACC_W'(cos_r);
   assign sin_e = ACC_W'(sin_r);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_acc   <= '0;
         y_acc   <= '0;
         xr_acc  <= '0;
         yr_acc  <= '0;
         u_cnt   <= '0;
         v_cnt   <= '0;
         gen_vld <= 1'b0;
      end else if (state == PREP) begin
         x_acc   <= x0;
         y_acc   <= y0;
         xr_acc  <= x0;
         yr_acc  <= y0;
         u_cnt   <= '0;
         v_cnt   <= '0;
         gen_vld <= 1'b1;
      end else if (state == EMIT && gen_vld && adv) begin
         if (u_cnt == U_LAST) begin
            u_cnt  <= '0;
            v_cnt  <= v_cnt + VW'(1);
            xr_acc <= xr_acc + sin_e;
            yr_acc <= yr_acc + cos_e;
            x_acc  <= xr_acc + sin_e;
            y_acc  <= yr_acc + cos_e;
            if (v_cnt == V_LAST) gen_vld <= 1'b0;
         end else begin
            u_cnt <= u_cnt + UW'(1);
            x_acc <= x_acc + cos_e;
            y_acc <= y_acc - sin_e;
         end
      end
   end

   assign xi   = IW'(round_q(64'(x_acc), FRAC));
   assign yi   = IW'(round_q(64'(y_acc), FRAC));
   assign x_in = !xi[IW-1] && (xi < COLS_S);
   assign y_in = !yi[IW-1] && (yi < ROWS_S);

`ifdef ROTATE_EDGE_CLAMP_EN
   localparam logic signed [IW-1:0] COLS_M1 = IW'(COLS - 1);
   localparam logic signed [IW-1:0] ROWS_M1 = IW'(ROWS - 1);
   assign xs  = xi[IW-1] ? '0 : (x_in ? xi : COLS_M1);
   assign ys  = yi[IW-1] ? '0 : (y_in ? yi : ROWS_M1);
   assign inb = 1'b1;
`else
   // Out-of-image reads are steered to address 0; their data is replaced by FILL.
   assign xs  = x_in ? xi : '0;
   assign ys  = y_in ? yi : '0;
   assign inb = x_in & y_in;
`endif

   assign rd_addr = AW'(ys) * AW'(COLS) + AW'(xs);

   frame_ram #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .AW     (AW)
   ) u_frame_ram (
      .clk     (clk),
      .wr_en   (in_beat),
      .wr_addr (wr_addr),
      .wr_dat  (s_data),
      .rd_en   (adv),
      .rd_addr (rd_addr),
      .rd_dat  (ram_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld2    <= 1'b0;
         meta2   <= '0;
         m_valid <= 1'b0;
         m_data  <= '0;
         m_eol   <= 1'b0;
         m_last  <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= (state == EMIT) && out_hs && m_last;
         if (adv) begin
            vld2       <= (state == EMIT) && gen_vld;
            meta2.eol  <= (u_cnt == U_LAST);
            meta2.last <= (u_cnt == U_LAST) && (v_cnt == V_LAST);
            meta2.inb  <= inb;
            m_valid    <= vld2;
            m_data     <= meta2.inb ? ram_q : FILL;
            m_eol      <= vld2 & meta2.eol;
            m_last     <= vld2 & meta2.last;
         end
      end
   end

endmodule

// File: tb/tb_image_rotate_stream.sv
// Two rotators (4x4 canvas and 6x6 canvas, both fed by the same 4x4 stream) checked against a per-pixel reference.
module tb_image_rotate_stream;
   import image_pkg::*;

   localparam int FR = DEF_FRAC;

   typedef struct {
      logic [7:0] data;
      bit         eol;
      bit         last;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [FR+1:0]    cos_q = '0;
   logic [FR+1:0]    sin_q = '0;
   logic             s_valid = 1'b0;
   logic [7:0]       s_data = '0;
   logic             m_ready = 1'b0;
   logic [1:0]       s_ready, m_valid, m_eol, m_last, busy, done;
   logic [1:0][7:0]  m_data;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   img [16];
   exp_t exp_a [$];
   exp_t exp_b [$];
   int   done_cnt [2] = '{0, 0};
   bit   rnd_rdy = 1'b0;

   always #5 clk = ~clk;

   image_rotate_stream #(
      .DATA_W(8), .ROWS(4), .COLS(4), .OUT_ROWS(4), .OUT_COLS(4), .FRAC(FR), .FILL(8'h00)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .cos_q(cos_q), .sin_q(sin_q),
      .s_valid(s_valid), .s_ready(s_ready[0]), .s_data(s_data),
      .m_valid(m_valid[0]), .m_ready(m_ready), .m_data(m_data[0]),
      .m_eol(m_eol[0]), .m_last(m_last[0]), .busy(busy[0]), .done(done[0])
   );

   image_rotate_stream #(
      .DATA_W(8), .ROWS(4), .COLS(4), .OUT_ROWS(6), .OUT_COLS(6), .FRAC(FR), .FILL(8'hEE)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .cos_q(cos_q), .sin_q(sin_q),
      .s_valid(s_valid), .s_ready(s_ready[1]), .s_data(s_data),
      .m_valid(m_valid[1]), .m_ready(m_ready), .m_data(m_data[1]),
      .m_eol(m_eol[1]), .m_last(m_last[1]), .busy(busy[1]), .done(done[1])
   );

   task automatic fail(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) fail(name, act, exp);
   endtask

   // Direct per-pixel formula, doubled so the half-integer centres stay exact.
   task automatic push_model(input int cs, input int sn);
      longint one;
      one = longint'(ONE_Q);
      for (int k = 0; k < 2; k++) begin
         int oc;
         oc = (k == 0) ? 4 : 6;
         for (int v = 0; v < oc; v++) begin
            for (int u = 0; u < oc; u++) begin
               longint du, dv, x2, y2, xi, yi;
               exp_t e;
               du = longint'(2 * u - (oc - 1));
               dv = longint'(2 * v - (oc - 1));
               x2 = 3 * one + du * cs + dv * sn;
               y2 = 3 * one - du * sn + dv * cs;
               xi = (x2 + one) >>> (FR + 1);
               yi = (y2 + one) >>> (FR + 1);
`ifdef ROTATE_EDGE_CLAMP_EN
               if (xi < 0) xi = 0;
               if (xi > 3) xi = 3;
               if (yi < 0) yi = 0;
               if (yi > 3) yi = 3;
`endif
               if (xi >= 0 && xi < 4 && yi >= 0 && yi < 4) e.data = 8'(img[int'(yi * 4 + xi)]);
               else e.data = (k == 0) ? 8'h00 : 8'hEE;
               e.eol  = (u == oc - 1);
               e.last = (u == oc - 1) && (v == oc - 1);
               if (k == 0) exp_a.push_back(e);
               else        exp_b.push_back(e);
            end
         end
      end
   endtask

   function automatic bit pop_exp(input int k, output exp_t e);
      if (k == 0) begin
         if (exp_a.size() == 0) return 1'b0;
         e = exp_a.pop_front();
      end else begin
         if (exp_b.size() == 0) return 1'b0;
         e = exp_b.pop_front();
      end
      return 1'b1;
   endfunction

   always begin
      @(posedge clk);
      #1;
      m_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   logic [1:0][7:0] held_d;
   logic [1:0]      held_eol, held_last, stall, done_pend;

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst_n) begin
         stall     = '0;
         done_pend = '0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (stall[k])
               check($sformatf("hold_under_stall_%0d", k),
                     {m_valid[k], m_eol[k], m_last[k], m_data[k]},
                     {1'b1, held_eol[k], held_last[k], held_d[k]});
            if (done_pend[k]) check($sformatf("done_after_last_%0d", k), done[k], 1);
            if (done[k]) done_cnt[k]++;
            if (m_valid[k] && m_ready) begin
               if (!pop_exp(k, e)) fail($sformatf("unexpected_pixel_%0d", k), m_data[k], 0);
               else begin
                  n_tests++;
                  if ({m_eol[k], m_last[k], m_data[k]} !== {e.eol, e.last, e.data})
                     fail($sformatf("pixel_%0d {eol,last,data}", k),
                          {m_eol[k], m_last[k], m_data[k]}, {e.eol, e.last, e.data});
               end
            end
            done_pend[k] = m_valid[k] && m_ready && m_last[k];
            stall[k]     = m_valid[k] && !m_ready;
            held_d[k]    = m_data[k];
            held_eol[k]  = m_eol[k];
            held_last[k] = m_last[k];
         end
      end
   end

   task automatic start_load(input int cs, input int sn, input bit rr, input bit gaps);
      bit         ok;
      logic [1:0] seen;
      push_model(cs, sn);
      rnd_rdy = rr;
      cos_q   = 16'(cs);
      sin_q   = 16'(sn);
      start   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("s_ready_after_start", s_ready, 2'b11);
      for (int i = 0; i < 16; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               s_valid = 1'b0;
               @(posedge clk);
               #1;
            end
         end
         s_valid = 1'b1;
         s_data  = 8'(img[i]);
         ok = 1'b0;
         for (int w = 0; w < 50 && !ok; w++) begin
            ok = &s_ready;
            @(posedge clk);
            #1;
         end
         if (!ok) fail("load_beat_timeout", i, 16);
      end
      s_valid = 1'b0;
      s_data  = 8'($urandom);
      seen = '0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         seen |= m_valid;
      end
      check("first_valid_within_4", seen, 2'b11);
   endtask

   task automatic run_frame(input int cs, input int sn, input bit rr, input bit gaps);
      int c0, c1;
      c0 = done_cnt[0];
      c1 = done_cnt[1];
      start_load(cs, sn, rr, gaps);
      for (int w = 0; w < 3000 && !(done_cnt[0] > c0 && done_cnt[1] > c1); w++) begin
         @(posedge clk);
         #1;
      end
      repeat (3) @(posedge clk);
      #1;
      check("done_count_a", done_cnt[0] - c0, 1);
      check("done_count_b", done_cnt[1] - c1, 1);
      check("pixels_left", exp_a.size() + exp_b.size(), 0);
      check("idle_after_frame", busy, 2'b00);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int c0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_flags", {s_ready, m_valid, m_eol, m_last, busy, done}, 0);
      check("reset_data", m_data, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 16; i++) img[i] = i;
      run_frame(ONE_Q, 0, 1'b0, 1'b0);
      run_frame(-ONE_Q, 0, 1'b0, 1'b0);
      run_frame(0, ONE_Q, 1'b0, 1'b0);
      run_frame(0, ONE_Q, 1'b1, 1'b1);

      for (int i = 0; i < 16; i++) img[i] = int'($urandom_range(0, 255));
      run_frame(14189, 8192, 1'b0, 1'b0);
      run_frame(14189, 8192, 1'b1, 1'b1);
      run_frame(11585, -11585, 1'b1, 1'b1);
      for (int r = 0; r < 3; r++)
         run_frame(int'($urandom_range(0, 32768)) - 16384,
                   int'($urandom_range(0, 32768)) - 16384, 1'b1, 1'b1);

      // Abort mid-emit, then a clean frame must still follow with a single done.
      for (int i = 0; i < 16; i++) img[i] = i;
      c0 = done_cnt[0];
      start_load(ONE_Q, 0, 1'b1, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      check("busy_mid_emit", busy, 2'b11);
      rst_n = 1'b0;
      #1;
      check("async_reset_flags", {s_ready, m_valid, m_eol, m_last, busy, done}, 0);
      check("async_reset_data", m_data, 0);
      exp_a.delete();
      exp_b.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("no_done_after_abort", done_cnt[0] - c0, 0);
      run_frame(ONE_Q, 0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
